// File: rtl/pc_flow_unit.sv
// -----------------------------------------------------------------------------
// pc_flow_unit
// -----------------------------------------------------------------------------
// Consumer side of the control decoder. Owns the architectural PC and the
// stored Z/V/N flag register, evaluates branch conditions against the stored
// flags, selects the next PC (sequential, register target, hold, PC-relative
// immediate) and runs the BOOT -> RUN -> HALTED state machine.
//
// Ports
//   clk          in   1      system clock, all state on rising edge
//   rst_n        in   1      asynchronous active-low reset
//   instr_valid  in   1      current instruction's controls are valid
//   stall        in   1      hold PC, flags and FSM this cycle
//   PCSour       in   2      00 pc+2, 01 reg_target, 10 hold, 11 pc+2+imm*2
//   fwr          in   3      flag write mask {Z,V,N}
//   HLT          in   1      halt request
//   cond         in   3      branch condition code
//   imm          in   IMM_W  signed word offset for PCSour=11
//   reg_target   in   PC_W   branch target for PCSour=01
//   alu_z/v/n    in   1      flags from the current ALU op
//   pc           out  PC_W   fetch address
//   pc_plus2     out  PC_W   pc+2 for link write-back
//   flags        out  3      stored {Z,V,N}
//   taken        out  1      current branch is taken (combinational)
//   halted       out  1      FSM is in HALTED
// -----------------------------------------------------------------------------
module pc_flow_unit #(
   parameter int unsigned     PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int unsigned     IMM_W    = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   input  logic             stall,
   input  logic [1:0]       PCSour,
   input  logic [2:0]       fwr,
   input  logic             HLT,
   input  logic [2:0]       cond,
   input  logic [IMM_W-1:0] imm,
   input  logic [PC_W-1:0]  reg_target,
   input  logic             alu_z,
   input  logic             alu_v,
   input  logic             alu_n,
   output logic [PC_W-1:0]  pc,
   output logic [PC_W-1:0]  pc_plus2,
   output logic [2:0]       flags,
   output logic             taken,
   output logic             halted
);

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   localparam logic [PC_W-1:0] PC_STEP = PC_W'(2);

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [2:0]        flags_q, flags_d;

   logic              z_f, v_f, n_f;
   logic              cond_true;
   logic              is_branch;
   logic [PC_W-1:0]   pc_inc;
   logic [PC_W-1:0]   imm_ext;
   logic [PC_W-1:0]   imm_off;
   logic [PC_W-1:0]   br_target;

   assign {z_f, v_f, n_f} = flags_q;

   // Branch condition is always judged on the stored flags, so a flag write
   // in the same instruction cannot influence its own branch.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      cond_true = 1'b0;
      case (cond)
         3'b000:  cond_true = ~z_f;
         3'b001:  cond_true = z_f;
         3'b010:  cond_true = ~z_f & ~n_f;
         3'b011:  cond_true = n_f;
         3'b100:  cond_true = z_f | ~n_f;
         3'b101:  cond_true = z_f | n_f;
         3'b110:  cond_true = v_f;
         default: cond_true = 1'b1;
      endcase
   end

   assign is_branch = (PCSour == 2'b01) || (PCSour == 2'b11);
   assign taken     = (state_q == ST_RUN) & instr_valid & ~HLT & cond_true & is_branch;

   // All PC arithmetic wraps at PC_W bits; the immediate counts words.
   assign pc_inc    = pc_q + PC_STEP;
   assign imm_ext   = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
   assign imm_off   = imm_ext << 1;
   assign br_target = pc_inc + imm_off;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flags_d = flags_q;
      case (state_q)
         ST_BOOT: begin
            if (!stall) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (instr_valid && !stall) begin
               if (HLT) begin
                  // PC parks on the halt instruction, flags untouched.
                  state_d = ST_HALTED;
               end else begin
                  flags_d = (flags_q & ~fwr) | ({alu_z, alu_v, alu_n} & fwr);
                  case (PCSour)
                     2'b00:   pc_d = pc_inc;
                     2'b01:   pc_d = taken ? reg_target : pc_inc;
                     2'b10:   pc_d = pc_q;
                     default: pc_d = taken ? br_target : pc_inc;
                  endcase
               end
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         flags_q <= 3'b000;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         state_q <= state_d;
         pc_q    <= pc_d;
         flags_q <= flags_d;
      end
   end

   assign pc       = pc_q;
   assign pc_plus2 = pc_inc;
   assign flags    = flags_q;
   assign halted   = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pc_flow_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_flow_unit
// Directed scenarios plus randomized traffic against a behavioural model of
// the PC / flag / halt rules.
// -----------------------------------------------------------------------------
module tb_pc_flow_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        stall = 1'b0;
   logic [1:0]  PCSour = 2'b00;
   logic [2:0]  fwr = 3'b000;
   logic        HLT = 1'b0;
   logic [2:0]  cond = 3'b000;
   logic [8:0]  imm = 9'h000;
   logic [15:0] reg_target = 16'h0000;
   logic        alu_z = 1'b0, alu_v = 1'b0, alu_n = 1'b0;
   logic [15:0] pc, pc_plus2;
   logic [2:0]  flags;
   logic        taken, halted;

   int checks = 0;
   int errors = 0;

   // behavioural model: mode 0 boot, 1 run, 2 halted
   int          m_mode;
   logic [15:0] m_pc;
   logic [2:0]  m_flags;

   pc_flow_unit dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .stall(stall),
      .PCSour(PCSour), .fwr(fwr), .HLT(HLT), .cond(cond), .imm(imm),
      .reg_target(reg_target), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
      .pc(pc), .pc_plus2(pc_plus2), .flags(flags), .taken(taken), .halted(halted)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog expired");
   end

   function automatic bit m_cond(input logic [2:0] c, input logic [2:0] f);
      bit z, v, n;
      z = f[2]; v = f[1]; n = f[0];
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || !n;
         3'd5: return z || n;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   function automatic bit m_taken();
      return (m_mode == 1) && instr_valid && !HLT && m_cond(cond, m_flags)
             && (PCSour == 2'b01 || PCSour == 2'b11);
   endfunction

   task automatic model_reset();
      m_mode = 0; m_pc = 16'h0000; m_flags = 3'b000;
   endtask

   task automatic set_in(input logic v, input logic s, input logic [1:0] ps,
                         input logic [2:0] fw, input logic h, input logic [2:0] c,
                         input logic [8:0] im, input logic [15:0] rt,
                         input logic [2:0] alu);
      instr_valid = v; stall = s; PCSour = ps; fwr = fw; HLT = h; cond = c;
      imm = im; reg_target = rt; {alu_z, alu_v, alu_n} = alu;
   endtask

   // One clock: derive the model's next state from the driven inputs, then
   // advance it at the edge and return 1 time unit later.
   task automatic tick();
      int          nm;
      logic [15:0] npc;
      logic [2:0]  nf;
      logic [2:0]  alu;
      bit          tk;
      int          t;
      nm = m_mode; npc = m_pc; nf = m_flags; tk = m_taken();
      alu = {alu_z, alu_v, alu_n};
      if (m_mode == 0) begin
         if (!stall) nm = 1;
      end else if (m_mode == 1 && instr_valid && !stall) begin
         if (HLT) nm = 2;
         else begin
            for (int i = 0; i < 3; i++) if (fwr[i]) nf[i] = alu[i];
            t = int'(m_pc) + 2;
            if (PCSour == 2'b01 && tk) t = int'(reg_target);
            if (PCSour == 2'b11 && tk) t = int'(m_pc) + 2 + 2 * int'($signed(imm));
            if (PCSour == 2'b10) t = int'(m_pc);
            npc = t[15:0];
         end
      end
      @(posedge clk);
      m_mode = nm; m_pc = npc; m_flags = nf;
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      set_in(1, 0, 2'b11, 3'b111, 0, 3'b111, 9'h004, 16'h1234, 3'b111);
      rst_n = 1'b0; #1;
      model_reset();
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 16'h0000); end
      checks++; if (flags !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp %b", flags, 3'b000); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
      checks++; if (taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b exp 0", taken); end
      @(posedge clk); #1;
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_hold_pc got %h exp %h", pc, 16'h0000); end
      rst_n = 1'b1; #1;
      checks++; if (taken !== 1'b0) begin errors++; $display("FAIL boot_taken got %b exp 0", taken); end
   endtask

   task automatic test_sequential();
      logic [15:0] exp_pc [4];
      exp_pc = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
      set_in(1, 0, 2'b00, 3'b000, 0, 3'b000, 9'h000, 16'h0000, 3'b000);
      #1;
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL seq_boot_pc got %h exp %h", pc, 16'h0000); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL seq_pc_%0d got %h exp %h", i, pc, exp_pc[i]); end
      end
      checks++; if (pc_plus2 !== 16'h0008) begin errors++; $display("FAIL seq_pc_plus2 got %h exp %h", pc_plus2, 16'h0008); end
   endtask

   task automatic test_branch_imm();
      set_in(1, 0, 2'b01, 3'b111, 0, 3'b111, 9'h000, 16'h000E, 3'b100);
      tick();
      checks++; if (pc !== 16'h000E) begin errors++; $display("FAIL bimm_setup_pc got %h exp %h", pc, 16'h000E); end
      checks++; if (flags !== 3'b100) begin errors++; $display("FAIL bimm_setup_flags got %b exp %b", flags, 3'b100); end
      set_in(1, 0, 2'b00, 3'b000, 0, 3'b000, 9'h000, 16'h0000, 3'b000);
      tick();
      set_in(1, 0, 2'b11, 3'b000, 0, 3'b001, 9'h1FE, 16'h0000, 3'b000);
      #1;
      checks++; if (taken !== 1'b1) begin errors++; $display("FAIL bimm_eq_taken got %b exp 1", taken); end
      tick();
      checks++; if (pc !== 16'h000E) begin errors++; $display("FAIL bimm_eq_pc got %h exp %h", pc, 16'h000E); end
      set_in(1, 0, 2'b00, 3'b000, 0, 3'b000, 9'h000, 16'h0000, 3'b000);
      tick();
      set_in(1, 0, 2'b11, 3'b000, 0, 3'b000, 9'h1FE, 16'h0000, 3'b000);
      #1;
      checks++; if (taken !== 1'b0) begin errors++; $display("FAIL bimm_ne_taken got %b exp 0", taken); end
      tick();
      checks++; if (pc !== 16'h0012) begin errors++; $display("FAIL bimm_ne_pc got %h exp %h", pc, 16'h0012); end
      checks++; if (flags !== 3'b100) begin errors++; $display("FAIL bimm_ne_flags got %b exp %b", flags, 3'b100); end
   endtask

   task automatic test_reg_branch();
      set_in(1, 0, 2'b00, 3'b111, 0, 3'b000, 9'h000, 16'h0000, 3'b111);
      tick();
      checks++; if (flags !== 3'b111) begin errors++; $display("FAIL rb_flags_all got %b exp %b", flags, 3'b111); end
      set_in(1, 0, 2'b00, 3'b100, 0, 3'b000, 9'h000, 16'h0000, 3'b000);
      tick();
      checks++; if (flags !== 3'b011) begin errors++; $display("FAIL rb_flags_mask got %b exp %b", flags, 3'b011); end
      set_in(1, 0, 2'b01, 3'b000, 0, 3'b110, 9'h000, 16'h1234, 3'b000);
      #1;
      checks++; if (taken !== 1'b1) begin errors++; $display("FAIL rb_ov_taken got %b exp 1", taken); end
      tick();
      checks++; if (pc !== 16'h1234) begin errors++; $display("FAIL rb_ov_pc got %h exp %h", pc, 16'h1234); end
      // flag write and branch together: EQ sees the old Z=0
      set_in(1, 0, 2'b11, 3'b100, 0, 3'b001, 9'h004, 16'h0000, 3'b100);
      #1;
      checks++; if (taken !== 1'b0) begin errors++; $display("FAIL rb_preupd_taken got %b exp 0", taken); end
      tick();
      checks++; if (pc !== 16'h1236) begin errors++; $display("FAIL rb_preupd_pc got %h exp %h", pc, 16'h1236); end
      checks++; if (flags !== 3'b111) begin errors++; $display("FAIL rb_preupd_flags got %b exp %b", flags, 3'b111); end
      set_in(1, 0, 2'b01, 3'b000, 0, 3'b111, 9'h000, 16'h1235, 3'b000);
      tick();
      checks++; if (pc !== 16'h1235) begin errors++; $display("FAIL rb_odd_pc got %h exp %h", pc, 16'h1235); end
      set_in(1, 0, 2'b01, 3'b000, 0, 3'b000, 9'h000, 16'h4444, 3'b000);
      tick();
      checks++; if (pc !== 16'h1237) begin errors++; $display("FAIL rb_nt_pc got %h exp %h", pc, 16'h1237); end
   endtask

   task automatic test_wrap();
      set_in(1, 0, 2'b01, 3'b000, 0, 3'b111, 9'h000, 16'hFFFE, 3'b000);
      tick();
      checks++; if (pc_plus2 !== 16'h0000) begin errors++; $display("FAIL wrap_plus2 got %h exp %h", pc_plus2, 16'h0000); end
      set_in(1, 0, 2'b00, 3'b000, 0, 3'b000, 9'h000, 16'h0000, 3'b000);
      tick();
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc got %h exp %h", pc, 16'h0000); end
      tick();
      set_in(1, 0, 2'b11, 3'b000, 0, 3'b111, 9'h100, 16'h0000, 3'b000);
      tick();
      checks++; if (pc !== 16'hFE04) begin errors++; $display("FAIL wrap_neg_pc got %h exp %h", pc, 16'hFE04); end
   endtask

   task automatic test_halt();
      set_in(1, 0, 2'b01, 3'b000, 0, 3'b111, 9'h000, 16'h0040, 3'b000);
      tick();
      set_in(1, 0, 2'b00, 3'b111, 1, 3'b111, 9'h000, 16'h0000, 3'b000);
      #1;
      checks++; if (taken !== 1'b0) begin errors++; $display("FAIL halt_taken got %b exp 0", taken); end
      tick();
      checks++; if (pc !== 16'h0040) begin errors++; $display("FAIL halt_pc got %h exp %h", pc, 16'h0040); end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b exp 1", halted); end
      checks++; if (flags !== 3'b111) begin errors++; $display("FAIL halt_flags got %b exp %b", flags, 3'b111); end
      set_in(1, 0, 2'b11, 3'b111, 0, 3'b111, 9'h004, 16'h0000, 3'b000);
      #1;
      checks++; if (taken !== 1'b0) begin errors++; $display("FAIL halted_taken got %b exp 0", taken); end
      repeat (3) tick();
      checks++; if (pc !== 16'h0040) begin errors++; $display("FAIL halted_pc got %h exp %h", pc, 16'h0040); end
      checks++; if (flags !== 3'b111) begin errors++; $display("FAIL halted_flags got %b exp %b", flags, 3'b111); end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted_stays got %b exp 1", halted); end
      rst_n = 1'b0; #1;
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL halt_rst_pc got %h exp %h", pc, 16'h0000); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_rst_halted got %b exp 0", halted); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_stall();
      set_in(1, 0, 2'b00, 3'b000, 0, 3'b000, 9'h000, 16'h0000, 3'b000);
      tick();
      set_in(1, 0, 2'b01, 3'b111, 0, 3'b111, 9'h000, 16'h0080, 3'b101);
      tick();
      checks++; if (pc !== 16'h0080) begin errors++; $display("FAIL stall_setup_pc got %h exp %h", pc, 16'h0080); end
      checks++; if (flags !== 3'b101) begin errors++; $display("FAIL stall_setup_flags got %b exp %b", flags, 3'b101); end
      set_in(0, 0, 2'b01, 3'b111, 0, 3'b111, 9'h000, 16'h2222, 3'b010);
      #1;
      checks++; if (taken !== 1'b0) begin errors++; $display("FAIL invalid_taken got %b exp 0", taken); end
      tick();
      checks++; if (pc !== 16'h0080) begin errors++; $display("FAIL invalid_pc got %h exp %h", pc, 16'h0080); end
      set_in(1, 1, 2'b11, 3'b111, 1, 3'b111, 9'h010, 16'h0000, 3'b010);
      repeat (2) tick();
      checks++; if (pc !== 16'h0080) begin errors++; $display("FAIL stall_hlt_pc got %h exp %h", pc, 16'h0080); end
      checks++; if (flags !== 3'b101) begin errors++; $display("FAIL stall_hlt_flags got %b exp %b", flags, 3'b101); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL stall_hlt_halted got %b exp 0", halted); end
      set_in(1, 1, 2'b01, 3'b111, 0, 3'b111, 9'h000, 16'h1111, 3'b010);
      tick();
      checks++; if (pc !== 16'h0080) begin errors++; $display("FAIL stall_br_pc got %h exp %h", pc, 16'h0080); end
      set_in(1, 0, 2'b11, 3'b111, 1, 3'b111, 9'h010, 16'h0000, 3'b010);
      tick();
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL unstall_halted got %b exp 1", halted); end
      checks++; if (pc !== 16'h0080) begin errors++; $display("FAIL unstall_pc got %h exp %h", pc, 16'h0080); end
      checks++; if (flags !== 3'b101) begin errors++; $display("FAIL unstall_flags got %b exp %b", flags, 3'b101); end
      apply_reset();
   endtask

   task automatic test_mid_reset();
      set_in(1, 0, 2'b00, 3'b000, 0, 3'b000, 9'h000, 16'h0000, 3'b000);
      repeat (3) tick();
      set_in(1, 0, 2'b01, 3'b111, 0, 3'b111, 9'h000, 16'h3000, 3'b111);
      @(negedge clk);
      rst_n = 1'b0; #1;
      model_reset();
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL midrst_pc got %h exp %h", pc, 16'h0000); end
      checks++; if (flags !== 3'b000) begin errors++; $display("FAIL midrst_flags got %b exp %b", flags, 3'b000); end
      @(posedge clk); #1;
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL midrst_hold_pc got %h exp %h", pc, 16'h0000); end
      checks++; if (flags !== 3'b000) begin errors++; $display("FAIL midrst_hold_flags got %b exp %b", flags, 3'b000); end
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [15:0] exp_p2;
      for (int n = 0; n < 600; n++) begin
         if (m_mode == 2 && ($urandom % 4) == 0) apply_reset();
         set_in(($urandom % 8) != 0, ($urandom % 6) == 0, 2'($urandom), 3'($urandom),
                ($urandom % 40) == 0, 3'($urandom), 9'($urandom), 16'($urandom), 3'($urandom));
         #1;
         checks++; if (taken !== m_taken()) begin errors++; $display("FAIL rnd_taken[%0d] got %b exp %b", n, taken, m_taken()); end
         tick();
         exp_p2 = m_pc + 16'd2;
         checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] got %h exp %h", n, pc, m_pc); end
         checks++; if (pc_plus2 !== exp_p2) begin errors++; $display("FAIL rnd_plus2[%0d] got %h exp %h", n, pc_plus2, exp_p2); end
         checks++; if (flags !== m_flags) begin errors++; $display("FAIL rnd_flags[%0d] got %b exp %b", n, flags, m_flags); end
         checks++; if (halted !== (m_mode == 2)) begin errors++; $display("FAIL rnd_halted[%0d] got %b exp %b", n, halted, m_mode == 2); end
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch_imm();
      test_reg_branch();
      test_wrap();
      test_halt();
      test_stall();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
